// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding from MEM/WB,
// the ALU, destination select and the EX/MEM pipeline register with stall/flush.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        write_IE,
  input  logic        MemtoReg_IE,
  input  logic        MemRead_IE,
  input  logic        MemWrite_IE,
  input  logic        regdst,
  input  logic        ALUsrc,
  input  logic [1:0]  ALUop,
  input  logic [4:0]  Rs_addr_IE,
  input  logic [4:0]  Rt_addr_IE,
  input  logic [4:0]  Rd_addr_IE,
  input  logic [31:0] Rs_data_IE,
  input  logic [31:0] Rt_data_IE,
  input  logic [31:0] imm_v,
  input  logic        write_WB,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        write_EM,
  output logic        MemtoReg_EM,
  output logic        MemRead_EM,
  output logic        MemWrite_EM,
  output logic [31:0] alu_result_EM,
  output logic [31:0] store_data_EM,
  output logic [4:0]  dst_addr_EM,
  output logic        zero_EM,
  output logic        overflow_EM
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_BAD
  } aluOp_t;

  logic        r_write;
  logic        r_memtoreg;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_alu_result;
  logic [31:0] r_store_data;
  logic [4:0]  r_dst;
  logic        r_zero;
  logic        r_overflow;

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic        w_overflow;
  logic        w_write;
  logic [4:0]  w_dst;
  aluOp_t      w_op;

  // The EX/MEM entry has priority over WB because it holds the younger value.
  always_comb begin
    w_fwd_a = Rs_data_IE;
    if (r_write && (r_dst != 5'd0) && (r_dst == Rs_addr_IE))
      w_fwd_a = r_alu_result;
    else if (write_WB && (wb_addr != 5'd0) && (wb_addr == Rs_addr_IE))
      w_fwd_a = wb_data;
  end

  always_comb begin
    w_fwd_b = Rt_data_IE;
    if (r_write && (r_dst != 5'd0) && (r_dst == Rt_addr_IE))
      w_fwd_b = r_alu_result;
    else if (write_WB && (wb_addr != 5'd0) && (wb_addr == Rt_addr_IE))
      w_fwd_b = wb_data;
  end

  assign w_op_b = ALUsrc ? imm_v : w_fwd_b;
  assign w_sum  = w_fwd_a + w_op_b;
  assign w_diff = w_fwd_a - w_op_b;
  assign w_dst  = regdst ? Rd_addr_IE : Rt_addr_IE;

  always_comb begin
    w_op = OP_BAD;
    case (ALUop)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b11: w_op = OP_SLT;
      default: begin
        case (imm_v[5:0])
          6'b100000: w_op = OP_ADD;
          6'b100010: w_op = OP_SUB;
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100110: w_op = OP_XOR;
          6'b100111: w_op = OP_NOR;
          6'b101010: w_op = OP_SLT;
          6'b101011: w_op = OP_SLTU;
          default:   w_op = OP_BAD;
        endcase
      end
    endcase
  end

  // An unrecognised R-type funct retires as a harmless non-writing zero.
  always_comb begin
    w_result   = 32'd0;
    w_overflow = 1'b0;
    w_write    = write_IE;
    case (w_op)
      OP_ADD: begin
        w_result   = w_sum;
        w_overflow = (w_fwd_a[31] == w_op_b[31]) && (w_sum[31] != w_fwd_a[31]);
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = (w_fwd_a[31] != w_op_b[31]) && (w_diff[31] != w_fwd_a[31]);
      end
      OP_AND:  w_result = w_fwd_a & w_op_b;
      OP_OR:   w_result = w_fwd_a | w_op_b;
      OP_XOR:  w_result = w_fwd_a ^ w_op_b;
      OP_NOR:  w_result = ~(w_fwd_a | w_op_b);
      OP_SLT:  w_result = {31'd0, ($signed(w_fwd_a) < $signed(w_op_b))};
      OP_SLTU: w_result = {31'd0, (w_fwd_a < w_op_b)};
      default: w_write  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_write      <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alu_result <= 32'd0;
      r_store_data <= 32'd0;
      r_dst        <= 5'd0;
      r_zero       <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (!stall) begin
      r_write      <= w_write;
      r_memtoreg   <= MemtoReg_IE;
      r_memread    <= MemRead_IE;
      r_memwrite   <= MemWrite_IE;
      r_alu_result <= w_result;
      r_store_data <= w_fwd_b;
      r_dst        <= w_dst;
      r_zero       <= (w_result == 32'd0);
      r_overflow   <= w_overflow;
    end
  end

  assign write_EM      = r_write;
  assign MemtoReg_EM   = r_memtoreg;
  assign MemRead_EM    = r_memread;
  assign MemWrite_EM   = r_memwrite;
  assign alu_result_EM = r_alu_result;
  assign store_data_EM = r_store_data;
  assign dst_addr_EM   = r_dst;
  assign zero_EM       = r_zero;
  assign overflow_EM   = r_overflow;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs, resolves operand forwarding from the MEM and WB stages, and performs the ALU operation. It selects the destination register and registers everything into EX/MEM on the rising clock edge, with stall and flush control. Downstream consumers are data memory and the MEM/WB register.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM contents (from the hazard unit)
- flush  in  1  load a bubble into EX/MEM
- write_IE, MemtoReg_IE, MemRead_IE, MemWrite_IE  in  1 each  control from ID/EX
- regdst, ALUsrc  in  1 each  EX control from ID/EX
- ALUop  in  2  ALU operation class
- Rs_addr_IE, Rt_addr_IE, Rd_addr_IE  in  5 each  register addresses
- Rs_data_IE, Rt_data_IE, imm_v  in  32 each  operands and sign-extended immediate
- write_WB  in  1  WB-stage register write enable
- wb_addr  in  5  WB-stage destination
- wb_data  in  32  WB-stage write-back value
- write_EM, MemtoReg_EM, MemRead_EM, MemWrite_EM  out  1 each  registered control
- alu_result_EM  out  32  registered ALU result / memory address
- store_data_EM  out  32  registered forwarded Rt value
- dst_addr_EM  out  5  registered destination register
- zero_EM  out  1  registered (alu_result == 0)
- overflow_EM  out  1  registered signed overflow for add/sub

## Operation
- Forward A (and B using Rt_addr_IE), in priority order:
  - MEM: write_EM && dst_addr_EM != 0 && dst_addr_EM == Rs_addr_IE -> alu_result_EM.
  - WB: write_WB && wb_addr != 0 && wb_addr == Rs_addr_IE -> wb_data.
  - Otherwise -> Rs_data_IE.
- MEM forwarding of a load result (MemRead_EM=1) is not possible. The hazard unit guarantees a stall in that case, and this block does not check for it.
- Operand B = ALUsrc ? imm_v : forwarded Rt. store_data = forwarded Rt regardless of ALUsrc.
- ALUop decode:
  - 00: add (lw/sw address)
  - 01: sub (beq)
  - 11: signed slt
  - 10: R-type, funct = imm_v[5:0]:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 100110 xor
    - 100111 nor
    - 101010 slt (signed)
    - 101011 sltu
    - any other funct -> result 0, write_EM forced 0
- Arithmetic: 32-bit wrap-around. overflow = signed overflow of add/sub, 0 for all other ops. Overflow does not suppress the write.
- slt/sltu result = {31'b0, cmp}.
- dst = regdst ? Rd_addr_IE : Rt_addr_IE.
- Register update priority per edge:
  - rst: all outputs 0.
  - else flush: bubble, i.e. all control outputs 0, data outputs 0, dst 0.
  - else stall: all outputs hold.
  - else: load computed values.
- Flush with stall simultaneously: flush wins.
- Reset mid-stall: reset wins, and stall has no effect the next cycle unless still asserted.

## Timing
- Latency: ID/EX values appear on EX/MEM outputs one clock after the edge at which they are presented. Forwarding paths and ALU are combinational within the cycle.
- Reset value of every output: 0 (bubble).
- A held (stalled) EX/MEM entry keeps forwarding its own alu_result_EM on subsequent cycles.
- Back-to-back dependent instructions need no stall except the load-use case.

## Test plan
- Reset: rst=1 for 2 cycles with nonzero inputs -> all outputs 0; release rst, present add Rs=5,Rt=7 -> alu_result_EM=12 after one edge.
- MEM forwarding: cycle n add r3 = 10+20 (dst 3); cycle n+1 sub Rs=r3 with Rs_data_IE=0, Rt_data_IE=4 -> alu_result_EM=26.
- Priority: both MEM (dst 3 -> 30) and WB (wb_addr=3, wb_data=99) match Rs=3 -> MEM value 30 used. With dst=0 and wb_addr=0, no forwarding occurs.
- Overflow/slt:
  - add 0x7FFFFFFF+1 -> 0x80000000, overflow_EM=1.
  - slt -1 vs 1 -> 1.
  - sltu -1 vs 1 -> 0.
  - sub 5-5 -> zero_EM=1.
- Stall/flush:
  - Stall 3 cycles -> outputs unchanged across all three.
  - flush with stall asserted -> all outputs 0 on the next edge.
  - sw with ALUsrc=1, imm=8, Rs=0x100, Rt=0xAB -> alu_result_EM=0x108, store_data_EM=0xAB, MemWrite_EM=1.
- Unknown funct 000001 with write_IE=1 -> alu_result_EM=0, write_EM=0.
